rotation_amount_finder: RTL and testbench
=========================================

// Module: rotation_amount_finder
// PURPOSE
//  Inverse of the multi-direction barrel shifter. Given an original word a and a
//  rotated word y, searches sequentially for the rotation that maps a onto y.
//  Reports the smallest left-rotate amount and its right-rotate equivalent.
//  Used to check and recover shifter settings on-chip. Multi-cycle: one candidate
//  per clock.
// PARAMETERS
//  N  3      log2 of word width; W = 2**N, amount fields are N bits wide
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   pulse; begin a search (sampled only in IDLE)
//  a          in   W   original word, captured on the accepted start edge
//  y          in   W   rotated word, captured on the accepted start edge
//  busy       out  1   high while in SEARCH
//  done       out  1   one-cycle pulse: result valid
//  found      out  1   1 = match exists; held until next accepted start
//  amt_left   out  N   smallest k with rotl(a,k)==y; held until next accepted start
//  amt_right  out  N   (W - amt_left) mod W; held until next accepted start
// BEHAVIOUR
//  - One clock, clk. reset is asynchronous, active-high.
//  - Reset value: every output is 0 (busy, done, found, amt_left, amt_right),
//    and the state is IDLE.
//  - rotl(x,k) = {x[W-1-k:0], x[W-1:W-k]}; rotl(x,0) = x.
//  - State IDLE:
//    - Edge with start=1: a_reg<=a, y_reg<=y, rot<=a, cand<=0, found<=0,
//      then go to SEARCH.
//    - start=0: stay.
//  - State SEARCH, per edge:
//    - If rot==y_reg: amt_left<=cand, amt_right<=(W-cand) mod W, found<=1,
//      go to DONE.
//    - Else if cand==W-1: found<=0, amt_left<=0, amt_right<=0, go to DONE.
//    - Else: rot<=rotl(rot,1), cand<=cand+1 (N-bit, never wraps in use).
//  - State DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency:
//    - Match at k: done is high in the cycle after edge k+1, counting the start edge as 0.
//    - No match: done is high after edge W.
//    - Next start is accepted in the cycle after done.
//  - busy=1 exactly in SEARCH. done and busy are never high together.
//  - start while busy or in DONE is ignored; it is not queued.
//    a and y changes after the accepted start have no effect.
//  - Periodic patterns (several k match): the smallest k is reported.
//  - a==y (including all-zero and all-one words): k=0, amt_right=0, done after edge 1.
//  - Reset mid-search: immediate return to IDLE, all outputs 0, no done pulse.
//  - All outputs are registered. No combinational input-to-output path.
// STRUCTURE
//  - Shared package rot_pkg:
//    - localparam W = 2**N
//    - typedef enum logic [1:0] {IDLE, SEARCH, DONE} rf_state_t
//    - function rotl1(word) for 1-bit left rotate; also reused by the shifter TB models
//  - No sub-module: one FSM with a datapath (rot register, cand counter, comparator).
// TESTING
//  1. a=8'b1101_0010, y=8'b1001_0110 -> found=1, amt_left=3, amt_right=5,
//     done after edge 4, busy for 4 cycles.
//  2. a=8'hAA, y=8'h55 -> found=1, amt_left=1, amt_right=7
//     (periodic; smallest k reported).
//  3. a=8'h00, y=8'h00 -> found=1, amt_left=0, amt_right=0, done after edge 1.
//  4. a=8'hFF, y=8'hFE -> found=0, amt_left=0, done after edge 8.
//     Second start during busy is ignored.
//  5. Assert reset 3 cycles into the search of case 1 -> all outputs 0
//     asynchronously, no done. New start after release gives the case-1 result.
//  6. Sweep all k=0..7 with a=8'b1101_0010, y=rotl(a,k)
//     -> amt_left=k, amt_right=(8-k)%8, outputs held between searches.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and helpers for the rotation finder and the shifter bench models.
package rot_pkg;
  localparam int N = 3;
  localparam int W = 2 ** N;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} rf_state_t;

  // Rotate a word left by one bit.
  function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction
endpackage

// File: rtl/rotation_amount_finder.sv
// Sequential search for the smallest left-rotate amount mapping a onto y.
// One candidate per clock: rot walks through rotl(a,k) while cand tracks k.
module rotation_amount_finder #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2**N-1:0] a,
  input  logic [2**N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] amt_left,
  output logic [N-1:0] amt_right
);
  import rot_pkg::*;

  localparam int WL = 2 ** N;

  rf_state_t r_state, w_next;

  logic [WL-1:0] r_rot;
  logic [WL-1:0] r_y;
  logic [N-1:0]  r_cand;
  logic          r_found;
  logic [N-1:0]  r_amt_l;
  logic [N-1:0]  r_amt_r;
  logic          r_busy;
  logic          r_done;

  logic w_match;
  logic w_last;

  assign w_match = (r_rot == r_y);
  assign w_last  = (r_cand == N'(WL - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SEARCH;
      SEARCH:  if (w_match || w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture operands on start, step the candidate, latch the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rot   <= '0;
      r_y     <= '0;
      r_cand  <= '0;
      r_found <= 1'b0;
      r_amt_l <= '0;
      r_amt_r <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rot   <= a;
            r_y     <= y;
            r_cand  <= '0;
            r_found <= 1'b0;
          end
        end
        SEARCH: begin
          if (w_match) begin
            r_amt_l <= r_cand;
            r_amt_r <= N'(0) - r_cand;  // (W - k) mod W in N bits
            r_found <= 1'b1;
          end else if (w_last) begin
            r_found <= 1'b0;
            r_amt_l <= '0;
            r_amt_r <= '0;
          end else begin
            r_rot  <= {r_rot[WL-2:0], r_rot[WL-1]};
            r_cand <= r_cand + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == SEARCH);
      r_done <= (w_next == DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign found     = r_found;
  assign amt_left  = r_amt_l;
  assign amt_right = r_amt_r;
endmodule

// File: tb/tb_rotation_amount_finder.sv
// Bench for rotation_amount_finder: directed cases plus randomized searches
// against a reference that tries every rotation of a.
module tb_rotation_amount_finder;
  localparam int N = 3;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic         found;
  logic [N-1:0] amt_left;
  logic [N-1:0] amt_right;

  int total = 0;
  int bad   = 0;

  rotation_amount_finder #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .y(y),
    .busy(busy), .done(done), .found(found),
    .amt_left(amt_left), .amt_right(amt_right)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int k);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = rot_pkg::rotl1(r);
    return r;
  endfunction

  // Reference: first k in 0..W-1 whose rotation of a equals y.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] my,
                       output bit mf, output int mk, output int medges);
    mf = 0; mk = 0; medges = W;
    for (int k = W - 1; k >= 0; k--)
      if (rotl(ma, k) == my) begin mf = 1; mk = k; end
    if (mf) medges = mk + 1;
  endtask

  // Launch a search and wait for done. edges counts rising edges after the
  // start edge; busy_cnt counts sampled cycles with busy high. At edge poke_at
  // a stray start with a=y=0 is pulsed, which would match at k=0 if accepted.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] ty, input int poke_at,
                     output int edges, output int busy_cnt, output bit overlap);
    @(negedge clk);
    a = ta; y = ty; start = 1;
    @(negedge clk);
    start = 0; edges = 0; busy_cnt = 0; overlap = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (edges == poke_at) begin start = 1; a = '0; y = '0; end
      else start = 0;
      @(negedge clk);
      edges++;
      if (busy && done) overlap = 1;
    end
    start = 0;
    if (edges >= 20) begin
      total++; bad++;
      $display("FAIL timeout: done not seen within 20 cycles (a=%h y=%h)", ta, ty);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0; a = '0; y = '0;
    #12;
    total++;
    if ({busy, done, found, amt_left, amt_right} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b l=%0d r=%0d want all 0",
               busy, done, found, amt_left, amt_right);
    end
    @(negedge clk); reset = 0;
    @(negedge clk);
  endtask

  task automatic test_case1();
    int e, b; bit ov;
    run(8'b1101_0010, 8'b1001_0110, -1, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b1, 3'd3, 3'd5}) begin
      bad++;
      $display("FAIL case1_result: got f=%b l=%0d r=%0d want 1 3 5", found, amt_left, amt_right);
    end
    total++;
    if (e != 4 || b != 4 || ov) begin
      bad++;
      $display("FAIL case1_timing: got edges=%0d busy=%0d overlap=%b want 4 4 0", e, b, ov);
    end
  endtask

  task automatic test_periodic();
    int e, b; bit ov;
    run(8'hAA, 8'h55, -1, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b1, 3'd1, 3'd7} || e != 2) begin
      bad++;
      $display("FAIL periodic: got f=%b l=%0d r=%0d edges=%0d want 1 1 7 2",
               found, amt_left, amt_right, e);
    end
  endtask

  task automatic test_zero();
    int e, b; bit ov;
    run(8'h00, 8'h00, -1, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b1, 3'd0, 3'd0} || e != 1) begin
      bad++;
      $display("FAIL zero_word: got f=%b l=%0d r=%0d edges=%0d want 1 0 0 1",
               found, amt_left, amt_right, e);
    end
    run(8'hFF, 8'hFF, -1, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b1, 3'd0, 3'd0} || e != 1) begin
      bad++;
      $display("FAIL ones_word: got f=%b l=%0d r=%0d edges=%0d want 1 0 0 1",
               found, amt_left, amt_right, e);
    end
  endtask

  task automatic test_nomatch_ignore();
    int e, b; bit ov;
    run(8'hFF, 8'hFE, 2, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b0, 3'd0, 3'd0} || e != 8 || b != 8) begin
      bad++;
      $display("FAIL nomatch: got f=%b l=%0d edges=%0d busy=%0d want 0 0 8 8",
               found, amt_left, e, b);
    end
    // start during the DONE cycle must be dropped
    start = 1; a = '0; y = '0;
    @(negedge clk); start = 0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int e, b; bit ov; bit saw_done;
    saw_done = 0;
    @(negedge clk);
    a = 8'b1101_0010; y = 8'b1001_0110; start = 1;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    total++;
    if ({busy, done, found, amt_left, amt_right} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b found=%b l=%0d r=%0d want all 0",
               busy, done, found, amt_left, amt_right);
    end
    @(negedge clk); reset = 0;
    repeat (5) begin @(negedge clk); if (done) saw_done = 1; end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_no_done: got done pulse after reset want none");
    end
    run(8'b1101_0010, 8'b1001_0110, -1, e, b, ov);
    total++;
    if ({found, amt_left, amt_right} !== {1'b1, 3'd3, 3'd5} || e != 4) begin
      bad++;
      $display("FAIL after_reset: got f=%b l=%0d r=%0d edges=%0d want 1 3 5 4",
               found, amt_left, amt_right, e);
    end
  endtask

  task automatic test_sweep();
    int e, b; bit ov;
    logic [W-1:0] base;
    base = 8'b1101_0010;
    for (int k = 0; k < W; k++) begin
      run(base, rotl(base, k), -1, e, b, ov);
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL done_pulse k=%0d: got done=%b one cycle later want 0", k, done);
      end
      repeat (3) @(negedge clk);
      total++;
      if ({found, amt_left, amt_right} !== {1'b1, 3'(k), 3'((W - k) % W)} || e != k + 1) begin
        bad++;
        $display("FAIL sweep k=%0d: got f=%b l=%0d r=%0d edges=%0d want 1 %0d %0d %0d",
                 k, found, amt_left, amt_right, e, k, (W - k) % W, k + 1);
      end
    end
  endtask

  task automatic test_random();
    int e, b, mk, me; bit ov, mf;
    logic [W-1:0] ra, ry;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(2))
        0:       ry = 8'($urandom);
        1:       ry = rotl(ra, int'($urandom_range(W - 1)));
        default: begin ra = {2{ra[3:0]}}; ry = rotl(ra, int'($urandom_range(W - 1))); end
      endcase
      model(ra, ry, mf, mk, me);
      run(ra, ry, -1, e, b, ov);
      total++;
      if (found !== mf || amt_left !== 3'(mk) || amt_right !== 3'((W - mk) % W) ||
          e != me || ov) begin
        bad++;
        $display("FAIL random a=%h y=%h: got f=%b l=%0d r=%0d edges=%0d want %b %0d %0d %0d",
                 ra, ry, found, amt_left, amt_right, e, mf, mk, (W - mk) % W, me);
      end
    end
  endtask

  initial begin
    test_reset();
    test_case1();
    test_periodic();
    test_zero();
    test_nomatch_ignore();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
